// File: rtl/mapu_row_packer.sv
// Row packer feeding the 3x3 matrix APU.
// Groups a serial element stream into 3-wide rows and queues them in a small row FIFO.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   i_clr               synchronous abort of partial row, FIFO and pair position
//   i_vld/o_rdy/i_data  upstream element handshake; i_op is sampled on element 0 of a pair
//   o_vld/i_rdy         downstream row handshake; o_r0..o_r2 carry the head row
//   o_en, o_op          APU enable and the op code of the pair in flight
//   o_pair_done         pulses the cycle after row 5 of a pair is transferred
module mapu_row_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clr,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_op,
    input  logic                  i_rdy,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_r0,
    output logic [DATA_WIDTH-1:0] o_r1,
    output logic [DATA_WIDTH-1:0] o_r2,
    output logic                  o_en,
    output logic [1:0]            o_op,
    output logic                  o_pair_done
);

    localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

    logic [1:0]            elem_idx;
    logic [2:0]            in_row;
    logic [2:0]            row_in_pair;
    logic [1:0]            op_cur;
    logic [DATA_WIDTH-1:0] asm0, asm1;
    logic [DATA_WIDTH-1:0] mem_r0 [2];
    logic [DATA_WIDTH-1:0] mem_r1 [2];
    logic [DATA_WIDTH-1:0] mem_r2 [2];
    logic [1:0]            mem_tag [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] hold_r0, hold_r1, hold_r2;
    logic [3:0]            win;

    logic acc, push, pop;

    // Ready looks only at registered state so the APU ready never
    // ripples back upstream; a full FIFO stalls only the row-closing beat.
    assign o_rdy = !i_clr && ((elem_idx != 2'd2) || (count != FULL_CNT));
    assign acc   = i_vld && o_rdy;
    assign push  = acc && (elem_idx == 2'd2);
    assign o_vld = (count != 2'd0);
    assign pop   = o_vld && i_rdy && !i_clr;

    // An empty FIFO keeps showing the last row handed downstream.
    assign o_r0 = o_vld ? mem_r0[rd_ptr] : hold_r0;
    assign o_r1 = o_vld ? mem_r1[rd_ptr] : hold_r1;
    assign o_r2 = o_vld ? mem_r2[rd_ptr] : hold_r2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_idx    <= 2'd0;
            in_row      <= 3'd0;
            row_in_pair <= 3'd0;
            op_cur      <= 2'd0;
            asm0        <= '0;
            asm1        <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_r0[i]  <= '0;
                mem_r1[i]  <= '0;
                mem_r2[i]  <= '0;
                mem_tag[i] <= 2'd0;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            hold_r0     <= '0;
            hold_r1     <= '0;
            hold_r2     <= '0;
            win         <= 4'd0;
            o_en        <= 1'b0;
            o_op        <= 2'd0;
            o_pair_done <= 1'b0;
        end else if (i_clr) begin
            elem_idx    <= 2'd0;
            in_row      <= 3'd0;
            row_in_pair <= 3'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            win         <= 4'd0;
            o_en        <= 1'b0;
            o_pair_done <= 1'b0;
        end else begin
            if (acc) begin
                elem_idx <= (elem_idx == 2'd2) ? 2'd0 : elem_idx + 2'd1;
                if (elem_idx == 2'd0) asm0 <= i_data;
                if (elem_idx == 2'd1) asm1 <= i_data;
                if (elem_idx == 2'd0 && in_row == 3'd0) op_cur <= i_op;
            end

            if (push) begin
                mem_r0[wr_ptr]  <= asm0;
                mem_r1[wr_ptr]  <= asm1;
                mem_r2[wr_ptr]  <= i_data;
                mem_tag[wr_ptr] <= op_cur;
                wr_ptr          <= ~wr_ptr;
                in_row          <= (in_row == 3'd5) ? 3'd0 : in_row + 3'd1;
            end

            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                hold_r0     <= mem_r0[rd_ptr];
                hold_r1     <= mem_r1[rd_ptr];
                hold_r2     <= mem_r2[rd_ptr];
                row_in_pair <= (row_in_pair == 3'd5) ? 3'd0 : row_in_pair + 3'd1;
            end

            unique case (1'b1)
                push && !pop: count <= count + 2'd1;
                pop && !push: count <= count - 2'd1;
                default:      count <= count;
            endcase

            o_pair_done <= pop && (row_in_pair == 3'd5);

            // Enable opens on a pair's first row and lingers eight cycles
            // past its done pulse; a new pair cancels the countdown.
            if (pop && row_in_pair == 3'd0) begin
                o_op <= mem_tag[rd_ptr];
                o_en <= 1'b1;
                win  <= 4'd0;
            end else if (o_pair_done) begin
                win <= 4'd8;
            end else if (win != 4'd0) begin
                win <= win - 4'd1;
                if (win == 4'd1) o_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mapu_row_packer.sv
// Self-checking bench for mapu_row_packer.
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_mapu_row_packer;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [1:0]  t;
    } row_t;

    localparam int INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_clr = 1'b0;
    logic        i_vld = 1'b0;
    logic        o_rdy;
    logic [31:0] i_data = '0;
    logic [1:0]  i_op = '0;
    logic        i_rdy = 1'b0;
    logic        o_vld;
    logic [31:0] o_r0, o_r1, o_r2;
    logic        o_en;
    logic [1:0]  o_op;
    logic        o_pair_done;

    mapu_row_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .i_clr(i_clr),
        .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data), .i_op(i_op),
        .i_rdy(i_rdy), .o_vld(o_vld),
        .o_r0(o_r0), .o_r1(o_r1), .o_r2(o_r2),
        .o_en(o_en), .o_op(o_op), .o_pair_done(o_pair_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // stimulus source and transfer log
    logic [31:0] src_d[$];
    logic [1:0]  src_o[$];
    logic [95:0] rlog[$];
    int          pd_seen = 0;
    bit          rnd_vld = 0, rnd_rdy = 0, rdy_lvl = 0;

    // reference model state
    logic [31:0] part[$];
    row_t        q[$];
    row_t        last, head, nr;
    int          in_row, out_row, cyc;
    logic [1:0]  op_cur, e_op;
    logic        e_pd, e_rdy, e_vld, e_en, xfer;
    int          cs, ce, ps, pe;

    task automatic m_clear();
        part.delete();
        q.delete();
        in_row = 0;
        out_row = 0;
        e_pd = 0;
        cs = INF; ce = -1; ps = INF; pe = -1;
    endtask

    initial begin
        cyc = 0;
        last = '0; op_cur = 0; e_op = 0;
        m_clear();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_vld", o_vld, 0);
                chk("rst_rdy", o_rdy, 1);
                chk("rst_en", o_en, 0);
                chk("rst_op", o_op, 0);
                chk("rst_pd", o_pair_done, 0);
                chk("rst_row", {o_r0, o_r1, o_r2}, 96'd0);
                m_clear();
                last = '0; op_cur = 0; e_op = 0;
            end else begin
                e_rdy = !i_clr && (part.size() != 2 || q.size() < 2);
                e_vld = q.size() != 0;
                head  = e_vld ? q[0] : last;
                e_en  = (cyc >= cs && cyc <= ce) || (cyc >= ps && cyc <= pe);
                chk("o_rdy", o_rdy, e_rdy);
                chk("o_vld", o_vld, e_vld);
                chk("o_row", {o_r0, o_r1, o_r2}, {head.a, head.b, head.c});
                chk("o_en", o_en, e_en);
                chk("o_op", o_op, e_op);
                chk("o_pd", o_pair_done, e_pd);
                if (o_pair_done) pd_seen++;
                if (i_clr) begin
                    m_clear();
                end else begin
                    xfer = e_vld && i_rdy;
                    e_pd = 0;
                    if (xfer) begin
                        rlog.push_back({o_r0, o_r1, o_r2});
                        last = q.pop_front();
                        if (out_row == 0) begin
                            e_op = last.t;
                            ps = cs; pe = ce;
                            cs = cyc + 1; ce = INF;
                        end
                        if (out_row == 5) begin
                            e_pd = 1;
                            ce = cyc + 9;
                        end
                        out_row = (out_row + 1) % 6;
                    end
                    if (i_vld && e_rdy) begin
                        if (part.size() == 0 && in_row == 0) op_cur = i_op;
                        part.push_back(i_data);
                        if (part.size() == 3) begin
                            nr = '{a: part[0], b: part[1], c: part[2], t: op_cur};
                            q.push_back(nr);
                            part.delete();
                            in_row = (in_row + 1) % 6;
                        end
                    end
                end
            end
        end
    end

    task automatic drive();
        i_vld  = (src_d.size() > 0) && (!rnd_vld || $urandom_range(0, 1) == 1);
        i_data = (src_d.size() > 0) ? src_d[0] : 32'd0;
        i_op   = (src_o.size() > 0) ? src_o[0] : 2'd0;
        i_rdy  = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_lvl;
    endtask

    task automatic step();
        bit acc;
        @(negedge clk);
        acc = i_vld && o_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_d.pop_front());
            void'(src_o.pop_front());
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((src_d.size() != 0 || o_vld) && k < max) begin
            step();
            k++;
        end
        chk("drain_timeout", k >= max, 0);
        run(3);
    endtask

    task automatic push(input logic [31:0] base, input int n, input logic [1:0] op);
        for (int k = 0; k < n; k++) begin
            src_d.push_back(base + 32'(k));
            src_o.push_back(op);
        end
    endtask

    task automatic chk_rows(input string nm, input logic [31:0] base, input int n);
        chk({nm, "_cnt"}, rlog.size(), n);
        for (int r = 0; r < n && r < rlog.size(); r++)
            chk(nm, rlog[r], {base + 32'(3*r), base + 32'(3*r+1), base + 32'(3*r+2)});
    endtask

    task automatic do_reset();
        src_d.delete();
        src_o.delete();
        i_vld = 0;
        #2;
        reset_n = 0;
        #1;
        chk("arst_vld", o_vld, 0);
        chk("arst_rdy", o_rdy, 1);
        chk("arst_en", o_en, 0);
        chk("arst_pd", o_pair_done, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        rlog.delete();
        pd_seen = 0;
        drive();
    endtask

    task automatic do_clear();
        i_clr  = 1;
        i_vld  = 1;
        i_data = 32'hbad0bad0;
        i_rdy  = 0;
        #1;
        chk("clr_rdy", o_rdy, 0);
        @(posedge clk);
        #1;
        i_clr = 0;
        chk("clr_vld", o_vld, 0);
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("init_rdy", o_rdy, 1);
        chk("init_row", {o_r0, o_r1, o_r2}, 96'd0);
        reset_n = 1;

        // one pair, always ready
        rdy_lvl = 1;
        push(32'd1, 18, 2'd1);
        drain(200);
        chk_rows("t1_row", 32'd1, 6);
        chk("t1_op", o_op, 1);
        chk("t1_pd", pd_seen, 1);
        run(12);
        chk("t1_en_off", o_en, 0);

        // backpressure fills the FIFO
        rlog.delete(); pd_seen = 0;
        rdy_lvl = 0;
        push(32'd1, 18, 2'd2);
        run(12);
        chk("t2_rdy", o_rdy, 0);
        chk("t2_left", src_d.size(), 10);
        chk("t2_vld", o_vld, 1);
        rdy_lvl = 1;
        drain(200);
        chk_rows("t2_row", 32'd1, 6);

        // two back-to-back pairs
        rlog.delete(); pd_seen = 0;
        push(32'd1, 18, 2'd1);
        push(32'd19, 18, 2'd0);
        drain(300);
        chk_rows("t3_row", 32'd1, 12);
        chk("t3_op", o_op, 0);
        chk("t3_pd", pd_seen, 2);

        // async reset mid-pair
        push(32'd1, 18, 2'd1);
        k = 0;
        while (src_d.size() > 11 && k < 100) begin step(); k++; end
        chk("t4_wait", k >= 100, 0);
        do_reset();
        push(32'd101, 18, 2'd3);
        drain(200);
        chk_rows("t4_row", 32'd101, 6);
        chk("t4_op", o_op, 3);

        // clear with two rows and one partial element buffered
        rlog.delete();
        rdy_lvl = 0;
        push(32'd201, 7, 2'd1);
        run(12);
        chk("t5_left", src_d.size(), 0);
        chk("t5_vld", o_vld, 1);
        do_clear();
        rdy_lvl = 1;
        push(32'd301, 6, 2'd2);
        drain(200);
        chk_rows("t5_row", 32'd301, 2);
        chk("t5_op", o_op, 2);

        // random handshakes over three pairs
        rlog.delete(); pd_seen = 0;
        i_clr = 1; i_rdy = 0; i_vld = 0;
        @(posedge clk); #1;
        i_clr = 0;
        rnd_vld = 1; rnd_rdy = 1;
        for (int p = 0; p < 3; p++)
            push(32'h80000000 + 32'(18*p), 18, 2'($urandom_range(0, 3)));
        drain(3000);
        chk_rows("t6_row", 32'h80000000, 18);
        chk("t6_pd", pd_seen, 3);

        rnd_vld = 0; rnd_rdy = 0;
        run(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mapu_row_packer.md
Name: mapu_row_packer

Overview:
- Upstream feeder for the 3x3 matrix APU.
- Accepts a serial stream of unsigned elements, one per beat, in row-major order: matrix A (9 elements), then matrix B (9 elements).
- Packs each group of 3 elements into a row, buffers rows in a 2-entry row FIFO, and presents them to the APU row interface with valid/ready.
- Carries the per-pair operation code alongside the rows and drives the APU enable/op lines.

Parameters:
- DATA_WIDTH, 32, width of one matrix element.
- FIFO_DEPTH, 2, row FIFO entries; legal values are 2 only.

Ports:
- clk  input  1  Clock.
- reset_n  input  1  Reset; asynchronous, active-low.
- i_clr  input  1  Synchronous abort; drops partial row, FIFO contents and pair position.
- i_vld  input  1  Upstream element valid.
- o_rdy  output  1  Upstream flow control; element accepted when i_vld && o_rdy.
- i_data  input  DATA_WIDTH  Upstream element.
- i_op  input  2  Operation code; sampled with element 0 of each pair.
- i_rdy  input  1  Downstream (APU) ready.
- o_vld  output  1  Row valid to APU.
- o_r0  output  DATA_WIDTH  Row element 0.
- o_r1  output  DATA_WIDTH  Row element 1.
- o_r2  output  DATA_WIDTH  Row element 2.
- o_en  output  1  APU enable.
- o_op  output  2  APU operation code.
- o_pair_done  output  1  One-cycle pulse when row 5 of a pair is transferred downstream.

Behaviour:
Reset:
- reset_n low asynchronously clears all state.
- o_vld=0, o_en=0, o_op=0, o_pair_done=0, o_r0..2=0, o_rdy=1.
- elem_idx=0, row_in_pair=0, FIFO empty.
- Reset mid-pair discards everything; no partial row is ever emitted after reset.

Input side:
- elem_idx counts 0..2 and wraps to 0.
- Elements 0 and 1 go into an assembly register.
- Element 2 completes the row; the row is written into the FIFO tail with its op tag in the same cycle.
- o_rdy = (elem_idx != 2) || (fifo_count < 2). o_rdy depends only on registered state; there is no combinational i_rdy->o_rdy path.
- When a pop and a push of a completing row land in the same cycle with the FIFO full, o_rdy is still 0 that cycle. This accepts one bubble in exchange for no comb path.
- in_row counts rows written, 0..5, wrapping 5->0.
- i_op is sampled into op_cur when an element is accepted with elem_idx==0 and in_row==0. All 6 rows of the pair carry op_cur as their tag.

Output side:
- o_vld = FIFO not empty.
- o_r0..2 = FIFO head row.
- Transfer happens when o_vld && i_rdy; the head pops in that cycle.
- o_r0..2 hold the last popped head when the FIFO is empty (no X, no zeroing).
- Push and pop in the same cycle: count is unchanged, ordering is preserved.
- Push into an empty FIFO: o_vld rises the next cycle, giving a latency of 1 cycle from the accepted 3rd element to o_vld.
- row_in_pair counts popped rows, 0..5.
- o_op is registered and updates to the head row's tag on pop of row 0 of a pair; it is stable for the remainder of the pair and until the next pair's row 0.
- o_pair_done pulses for 1 cycle on the pop of row 5.

Enable:
- o_en is set on the pop of row 0 of a pair.
- o_en stays high through 8 cycles after o_pair_done (covers APU compute plus 3 output rows), then clears.
- If a new pair's row 0 pops during that window, o_en remains high and the 8-cycle window restarts from that pair's o_pair_done.

Clear:
- i_clr high on a rising edge: FIFO emptied, elem_idx=0, in_row=0, row_in_pair=0, o_en=0, o_vld=0 next cycle.
- An element presented in the same cycle is dropped. o_rdy is forced 0 while i_clr=1.

Arithmetic:
- No data transformation; elements pass bit-exact. Counter widths are 2 and 3 bits.

Test Plan:
- Reset, then stream elements 1..18 with i_op=1 on element 0 and i_rdy=1 -> 6 rows out: (1,2,3),(4,5,6)...(16,17,18); o_op=1 from first row; o_pair_done pulses once on the row (16,17,18).
- Same stream with i_rdy=0 -> FIFO fills after 6 elements; o_rdy=0 on element 9 (elem_idx=2, count=2). Raise i_rdy -> rows drain in order, none lost or duplicated.
- Two back-to-back pairs: op=1 then op=0 -> o_op switches 1->0 exactly on pop of row 0 of pair 2; o_en stays high continuously across both pairs.
- Assert reset_n=0 asynchronously after element 7 of a pair -> outputs reset immediately. Restream 18 elements -> first row out is the new elements 1..3.
- i_clr for 1 cycle with 2 rows buffered and 1 partial element -> o_vld=0 next cycle; the next 3 elements form row 0 with the op resampled.
- Alternate i_vld and i_rdy toggling randomly over 3 pairs with elements 0x80000000..+53 -> output rows are bit-exact in order; each o_pair_done follows every 6th transfer.
